// File: rtl/meteo_pkg.sv
// Shared types, constants and elaboration helpers for the BME280 display path.
package meteo_pkg;

  localparam int unsigned BME_WIDTH  = 32;
  localparam int unsigned BME_DIGITS = 10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Smallest n with 2^n >= value.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned     res;
    longint unsigned pw;
    res = 0;
    pw  = 64'd1;
    while (pw < 64'(value)) begin
      pw  = pw << 1;
      res = res + 1;
    end
    return res;
  endfunction

  // Smallest digit count d with 10^d > 2^width.
  function automatic int unsigned min_digits(input int unsigned width);
    real         lim;
    real         pw;
    int unsigned d;
    lim = 1.0;
    for (int unsigned i = 0; i < width; i++) begin
      lim = lim * 2.0;
    end
    pw = 1.0;
    d  = 0;
    while (pw <= lim) begin
      pw = pw * 10.0;
      d  = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more.
module bcd_digit_adj (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Pre-shift correction so the following left shift carries into the next digit.
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'd5) begin
      o_digit = i_digit + 4'd3;
    end
  end

endmodule

// File: rtl/seq_bin2bcd.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// optional two's-complement input; results update only on the Done edge.
module seq_bin2bcd
  import meteo_pkg::*;
#(
  parameter int unsigned WIDTH  = BME_WIDTH,
  parameter int unsigned DIGITS = BME_DIGITS,
  parameter int unsigned SIGNED = 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      Bin,
  output logic                  Busy,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   Bcd,
  output logic                  Sign
);

  localparam int unsigned CNT_W = clog2(WIDTH + 1);
  localparam int unsigned BCD_W = 4 * DIGITS;

  // Reject configurations whose digit count cannot hold the full input range.
  generate
    if (DIGITS < min_digits(WIDTH)) begin : g_cfg_err
      $error("seq_bin2bcd: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [WIDTH-1:0]   r_shreg;
  logic [WIDTH-1:0]   w_shreg_nxt;
  logic [BCD_W-1:0]   r_acc;
  logic [BCD_W-1:0]   w_acc_nxt;
  logic [BCD_W-1:0]   w_acc_adj;
  logic [BCD_W-1:0]   w_acc_shift;
  logic               r_neg;
  logic               w_neg_nxt;
  logic               w_bin_neg;
  logic [WIDTH-1:0]   w_mag;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic [BCD_W-1:0]   w_bcd_nxt;
  logic               w_sign_nxt;

  // Sign detection and magnitude; the most negative value negates to itself,
  // which is its correct unsigned magnitude.
  assign w_bin_neg = (SIGNED != 0) ? Bin[WIDTH-1] : 1'b0;
  assign w_mag     = w_bin_neg ? (WIDTH'(0) - Bin) : Bin;

  // Per-digit add-3 correction on the accumulator.
  generate
    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_adj
      bcd_digit_adj u_adj (
        .i_digit (r_acc[4*g +: 4]),
        .o_digit (w_acc_adj[4*g +: 4])
      );
    end
  endgenerate

  // Corrected accumulator shifted left, pulling in the next binary bit.
  assign w_acc_shift = BCD_W'({w_acc_adj, r_shreg[WIDTH-1]});

  // Next-state and datapath/output next values.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shreg_nxt = r_shreg;
    w_acc_nxt   = r_acc;
    w_neg_nxt   = r_neg;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_bcd_nxt   = Bcd;
    w_sign_nxt  = Sign;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_shreg_nxt = w_mag;
          w_acc_nxt   = '0;
          w_neg_nxt   = w_bin_neg;
          w_cnt_nxt   = CNT_W'(WIDTH);
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_acc_nxt   = w_acc_shift;
        w_shreg_nxt = r_shreg << 1;
        w_cnt_nxt   = r_cnt - CNT_W'(1);
        w_busy_nxt  = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_bcd_nxt   = w_acc_shift;
          w_sign_nxt  = r_neg;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, working registers and registered outputs; reset abandons any conversion.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_acc   <= '0;
      r_neg   <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Bcd     <= '0;
      Sign    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shreg <= w_shreg_nxt;
      r_acc   <= w_acc_nxt;
      r_neg   <= w_neg_nxt;
      Busy    <= w_busy_nxt;
      Done    <= w_done_nxt;
      Bcd     <= w_bcd_nxt;
      Sign    <= w_sign_nxt;
    end
  end

endmodule
